// File: rtl/cpu_out_bcd.sv
// rtl/cpu_out_bcd.sv - sequential double-dabble binary-to-BCD converter for the CPU out port
// One shift/add-3 iteration per cycle; a new conversion starts whenever the input differs from the last one converted.
module cpu_out_bcd #(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in,
  output logic [4*DIGITS-1:0]     bcd,
  output logic                    valid,
  output logic                    busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [4*DIGITS-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   acc_shift;
  logic [DATA_WIDTH-1:0] sh_shift;

  // Add-3 correction on every digit >= 5, then shift {acc, sh} left by one.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    {acc_shift, sh_shift} = {adj, sh_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (in != last_q) begin
          sh_d    = in;
          last_d  = in;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d  = sh_shift;
        acc_d = acc_shift;
        if (cnt_q == LAST_CNT) begin
          bcd_d   = acc_shift;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bcd   = bcd_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: doc/cpu_out_bcd.md
CPU_OUT_BCD -- requirements
Module: cpu_out_bcd

Interface
REQ-001 The block SHALL have one parameter, DATA_WIDTH, default 16: width of the binary value from the CPU out port.
REQ-002 The block SHALL have one parameter, DIGITS, default 5: number of BCD digits produced.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in, input, DATA_WIDTH bits: unsigned binary value, driven by the CPU "out" register.
REQ-006 Port bcd, output, 4*DIGITS bits: registered BCD result; digit 0 (units) is in bcd[3:0].
REQ-007 Port valid, output, 1 bit: registered one-cycle pulse; high means bcd was updated on the preceding edge.
REQ-008 Port busy, output, 1 bit: registered; high while a conversion is in progress.

Function
REQ-009 The block SHALL implement a two-state FSM:
  - IDLE: waiting for a changed input.
  - CONV: running the conversion.
REQ-010 The block SHALL hold the following registers:
  - last (DATA_WIDTH): last converted value.
  - sh (DATA_WIDTH): shift register.
  - acc (4*DIGITS): digit accumulator.
  - cnt: iteration counter, 0..DATA_WIDTH-1.
REQ-011 In IDLE, on an edge where in != last:
  - sh <= in, last <= in, acc <= 0, cnt <= 0;
  - busy <= 1, state <= CONV.
REQ-012 In IDLE with in == last, the block SHALL hold all registers and keep valid and busy at 0.
REQ-013 In CONV, each edge SHALL perform one double-dabble iteration:
  - every acc digit >= 5 is first incremented by 3;
  - then {acc, sh} is shifted left by 1, with sh MSB entering acc LSB.
REQ-014 The digit adjust and shift SHALL be evaluated combinationally within the same cycle; acc digits SHALL never hold values above 9 after an edge.
REQ-015 On the CONV edge with cnt == DATA_WIDTH-1, the block SHALL:
  - load bcd with the post-shift acc value;
  - set valid <= 1, busy <= 0, state <= IDLE.
REQ-016 On all other CONV edges, cnt SHALL increment by 1 and valid SHALL stay 0.
REQ-017 Latency: if a change is captured on edge k, bcd and valid SHALL update on edge k+DATA_WIDTH (default k+16), with valid high for exactly one cycle.
REQ-018 Changes of in during CONV SHALL be ignored.
REQ-019 After returning to IDLE, if in differs from last, a new conversion SHALL start on the next edge; the minimum spacing of valid pulses is therefore DATA_WIDTH+1 cycles.
REQ-020 bcd SHALL hold its value between conversions; valid SHALL be 0 in every cycle except the one defined in REQ-015.
REQ-021 The full unsigned range SHALL convert exactly, e.g. 65535 -> 20'h65535; DIGITS*4 bits SHALL be sufficient for 2^DATA_WIDTH-1.
REQ-022 Consumers SHALL sample bcd only when valid is high or busy is low.

Reset
REQ-023 While rst is high at a rising edge, the block SHALL set:
  - state <= IDLE;
  - bcd <= 0, valid <= 0, busy <= 0;
  - last <= 0, sh <= 0, acc <= 0, cnt <= 0.
REQ-024 Reset SHALL take priority over any FSM action, including the final CONV iteration.
REQ-025 A conversion interrupted by reset SHALL be abandoned with no valid pulse.
REQ-026 After reset, in == 0 SHALL trigger no conversion, since bcd == 0 is already correct.

Verification
REQ-027 Reset scenario: rst high 2 cycles with in=0, then hold in=0 for 40 cycles -> bcd=0, valid never asserts, busy stays 0.
REQ-028 Basic conversion: in=16'd1234 applied at edge k -> busy=1 from k; at edge k+16, bcd=20'h01234, valid=1 for 1 cycle, busy=0.
REQ-029 Extremes:
  - in=16'd65535 -> bcd=20'h65535;
  - then in=16'd9 -> bcd=20'h00009;
  - then in=16'd10 -> bcd=20'h00010;
  - each with one valid pulse.
REQ-030 Change during conversion: in=100 at edge k, in=200 at edge k+5 -> valid at k+16 with bcd=20'h00100, then a second conversion starting k+17, with valid at k+33 and bcd=20'h00200.
REQ-031 Mid-conversion reset: in=500, rst pulsed at edge k+8 -> no valid pulse and bcd=0. With in still 500 after reset, a conversion starts on the first post-reset edge and yields 20'h00500.
REQ-032 Steady input: in held at 4321 for 100 cycles after its conversion -> exactly one valid pulse total, and bcd stays 20'h04321.
